// File: rtl/clken_pkg.sv
// clken_pkg: shared FSM type, default rates and helpers for clken_gen.
// Runtime rate writes are enabled with CLKEN_RUNTIME_RATE_EN.
package clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    STAGGER,
    RUN
  } clken_state_e;

  localparam int CLKEN_ACC_W = 24;

  // 24/12/6 MHz from a 48 MHz refclk, channel 0 in the LSBs
  localparam logic [3*CLKEN_ACC_W-1:0] CLKEN_INC = {
    24'h200000,
    24'h400000,
    24'h800000
  };

  function automatic longint unsigned clken_calc_inc(
    input longint unsigned f_clk,
    input longint unsigned f_out,
    input int              acc_w
  );
    return ((f_out << acc_w) + (f_clk >> 1)) / f_clk;
  endfunction

  function automatic int clken_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clken_nco.sv
// clken_nco: one phase accumulator; pulse is the registered
// carry-out of each add.
module clken_nco
  import clken_pkg::*;
#(
  parameter int ACC_W = CLKEN_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             pulse
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      pulse <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      pulse <= 1'b0;
    end else begin
      acc   <= sum[ACC_W-1:0];
      pulse <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/clken_gen.sv
// clken_gen: lock-qualified, staggered reset release plus NCH
// fractional clock enables. Optional CLKEN_RUNTIME_RATE_EN.
module clken_gen
  import clken_pkg::*;
#(
  parameter int                   NCH         = 3,
  parameter int                   ACC_W       = CLKEN_ACC_W,
  parameter logic [NCH*ACC_W-1:0] INC         = CLKEN_INC,
  parameter int                   LOCK_CYCLES = 1024,
  parameter int                   RST_STAGGER = 16
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          locked,
`ifdef CLKEN_RUNTIME_RATE_EN
  input  logic                          inc_we,
  input  logic [clken_sel_w(NCH)-1:0]   inc_sel,
  input  logic [ACC_W-1:0]              inc_data,
`endif
  output logic [NCH-1:0]                clken,
  output logic [NCH-1:0]                chan_rst,
  output logic                          ready
);

  localparam int STG_LEN = (NCH - 1) * RST_STAGGER + 1;
  localparam int CNT_MAX =
    (LOCK_CYCLES > STG_LEN) ? LOCK_CYCLES : STG_LEN;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  logic [1:0] rst_sync;
  logic       rst_i;
  logic [1:0] lk_sync;
  logic       lk_s;

  // rst asserts immediately, releases two edges later
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b11;
      lk_sync  <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
      lk_sync  <= {lk_sync[0], locked};
    end
  end

  assign rst_i = rst_sync[1];
  assign lk_s  = lk_sync[1];

  clken_state_e     state;
  clken_state_e     state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [NCH-1:0]   chan_rst_d;
  logic             drop;

  function automatic logic [NCH-1:0] held(
    input logic [CNT_W-1:0] c
  );
    held = '1;
    for (int k = 0; k < NCH; k++) begin
      held[k] = int'(c) < k * RST_STAGGER;
    end
  endfunction

  always_ff @(posedge refclk or posedge rst_i) begin
    if (rst_i) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      chan_rst <= '1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      chan_rst <= chan_rst_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = '0;
    chan_rst_d = '1;
    drop       = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (lk_s) begin
          state_d = FILTER;
        end
      end
      FILTER: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d    = STAGGER;
          chan_rst_d = held('0);
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STAGGER: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          drop    = 1'b1;
        end else if (cnt == CNT_W'(STG_LEN - 1)) begin
          state_d    = RUN;
          chan_rst_d = '0;
        end else begin
          cnt_d      = cnt + CNT_W'(1);
          chan_rst_d = held(cnt_d);
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          drop    = 1'b1;
        end else begin
          chan_rst_d = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  assign ready = (state == RUN);

  logic [ACC_W-1:0] inc_q [NCH];

`ifdef CLKEN_RUNTIME_RATE_EN
  localparam int SEL_W = clken_sel_w(NCH);

  // out-of-range selects match no channel and are dropped
  always_ff @(posedge refclk or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        inc_q[k] <= INC[k*ACC_W +: ACC_W];
      end
    end else if (inc_we) begin
      for (int k = 0; k < NCH; k++) begin
        if (inc_sel == SEL_W'(k)) begin
          inc_q[k] <= inc_data;
        end
      end
    end
  end
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
`ifndef CLKEN_RUNTIME_RATE_EN
    assign inc_q[k] = INC[k*ACC_W +: ACC_W];
`endif
    // drop kills the carry already in flight on lock loss
    clken_nco #(
      .ACC_W(ACC_W)
    ) u_nco (
      .clk  (refclk),
      .rst  (rst_i),
      .clr  (chan_rst[k] | drop),
      .inc  (inc_q[k]),
      .pulse(clken[k])
    );
  end

endmodule
